ps2_host_tx: RTL

//  Host-to-device PS/2 transmitter. Sends one command byte (e.g. 8'hFF reset, 8'hED set-LEDs)
//  to the keyboard on the same KB clock/data pins that the kbInput receive path reads.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_line_filter.sv | 40 ++++
 rtl/ps2_host_tx.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 types and constants for the host transmit and keyboard receive paths.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RELEASE,
    SEND,
    ACK,
    WAIT_IDLE,
    ERROR
  } ps2_tx_state_e;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] ACK_FA       = 8'hFA;

  // PS/2 frames carry odd parity over the data byte.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes an asynchronous PS/2 line, rejects glitches shorter than FILTER_LEN
// samples and strobes for one cycle when the filtered level falls.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic fall
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Line idles high, so the synchronizer and filtered level reset to 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      fall <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= sync[1];
        cnt   <= '0;
        fall  <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, sends one command byte with
// odd parity, and checks the device ack, driving both lines open-drain.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       master_clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned INH_W = 13;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BIT_W = 4;

  ps2_tx_state_e    state, state_d;
  logic [INH_W-1:0] inh_cnt, inh_cnt_d;
  logic [TO_W-1:0]  to_cnt, to_cnt_d;
  logic [BIT_W-1:0] bit_idx, bit_idx_d;
  logic [7:0]       shreg, shreg_d;
  logic             parity, parity_d;
  logic             clk_oe_d, data_oe_d, done_d, error_d;
  logic             clk_level, clk_fall;
  logic [1:0]       data_sync;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (master_clk),
    .reset (reset),
    .raw   (ps2_clk_in),
    .level (clk_level),
    .fall  (clk_fall)
  );

  always_ff @(posedge master_clk) begin
    if (reset) data_sync <= 2'b11;
    else       data_sync <= {data_sync[0], ps2_data_in};
  end

  always_comb begin
    state_d   = state;
    inh_cnt_d = inh_cnt;
    to_cnt_d  = to_cnt;
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    parity_d  = parity;
    clk_oe_d  = 1'b0;
    data_oe_d = ps2_data_oe;
    done_d    = 1'b0;
    error_d   = 1'b0;

    case (state)
      IDLE: begin
        data_oe_d = 1'b0;
        if (tx_valid && tx_ready) begin
          shreg_d   = tx_data;
          parity_d  = odd_parity(tx_data);
          inh_cnt_d = '0;
          to_cnt_d  = '0;
          bit_idx_d = '0;
          clk_oe_d  = 1'b1;
          data_oe_d = (INHIBIT_CYCLES == 1);
          state_d   = INHIBIT;
        end
      end
      // Start bit is pulled low on the final inhibit cycle.
      INHIBIT: begin
        if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
          inh_cnt_d = '0;
          data_oe_d = 1'b1;
          state_d   = RELEASE;
        end else begin
          clk_oe_d  = 1'b1;
          inh_cnt_d = inh_cnt + 1'b1;
          data_oe_d = (inh_cnt_d == INH_W'(INHIBIT_CYCLES - 1));
        end
      end
      RELEASE: begin
        data_oe_d = 1'b1;
        to_cnt_d  = '0;
        bit_idx_d = '0;
        state_d   = SEND;
      end
      SEND: begin
        if (clk_fall) begin
          bit_idx_d = bit_idx + 1'b1;
          if (bit_idx < 4'd8) begin
            data_oe_d = ~shreg[bit_idx[2:0]];
          end else if (bit_idx == 4'd8) begin
            data_oe_d = ~parity;
          end else begin
            data_oe_d = 1'b0;
            state_d   = ACK;
          end
        end
      end
      ACK: begin
        if (clk_fall) state_d = data_sync[1] ? ERROR : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (clk_level && data_sync[1]) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      ERROR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Timeout overrides any in-flight decision, including a same-cycle done.
    if (state inside {SEND, ACK, WAIT_IDLE}) begin
      if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = ERROR;
        done_d  = 1'b0;
      end else begin
        to_cnt_d = to_cnt + 1'b1;
      end
    end

    if (state_d == ERROR) begin
      error_d   = 1'b1;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
    end
  end

  always_ff @(posedge master_clk) begin
    if (reset) begin
      state       <= IDLE;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      parity      <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
    end else begin
      state       <= state_d;
      inh_cnt     <= inh_cnt_d;
      to_cnt      <= to_cnt_d;
      bit_idx     <= bit_idx_d;
      shreg       <= shreg_d;
      parity      <= parity_d;
      ps2_clk_oe  <= clk_oe_d;
      ps2_data_oe <= data_oe_d;
      tx_ready    <= (state_d == IDLE);
      busy        <= (state_d != IDLE);
      tx_done     <= done_d;
      tx_error    <= error_d;
    end
  end

endmodule
